act_buf_pingpong_ctrl: RTL and testbench

- Double-buffer (ping-pong) scheduler for the 1536x32 activation-buffer BRAM shared by the activation writer and the PE.
- Splits the BRAM into two banks and grants the writer an empty bank.
- Announces each filled bank to the PE over the SyncSig valid/ack handshake, and recycles a bank once the PE reports it drained.
- Translates writer and PE local addresses to physical BRAM addresses and gates illegal accesses.

---
 rtl/act_buf_pingpong_ctrl_if.sv | 64 ++++++
 rtl/act_buf_pingpong_ctrl.sv | 163 ++++++++++++++++
 tb/tb_act_buf_pingpong_ctrl.sv | 303 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/act_buf_pingpong_ctrl_if.sv
// ---------------------------------------------------------------------------
// act_buf_pingpong_ctrl_if
//   Bundles the writer, PE and BRAM-side signals of the activation-buffer
//   ping-pong controller.
//
//   master : the clients (activation writer + PE). Drives requests, local
//            addresses, enables, done pulses and the SyncSig ack.
//   slave  : the controller. Drives grant, SyncSig valid/id, the physical
//            BRAM address/enable signals, full_count and the error flags.
// ---------------------------------------------------------------------------
interface act_buf_pingpong_ctrl_if #(
  parameter int AWIDTH = 11,
  parameter int LWIDTH = 10
);

  // Writer side
  logic              wr_req;
  logic              wr_grant;
  logic              wr_done;
  logic [LWIDTH-1:0] wr_addr;
  logic              wr_ce;
  logic              wr_we;

  // BRAM write port
  logic [AWIDTH-1:0] ActBuf_Data_V_address1;
  logic              ActBuf_Data_V_ce1;
  logic              ActBuf_Data_V_we1;

  // Bank-ready handshake to the PE
  logic              SyncSig_V;
  logic              SyncSig_V_ap_vld;
  logic              SyncSig_V_ap_ack;

  // PE side
  logic [LWIDTH-1:0] rd_addr;
  logic              rd_ce;
  logic              rd_done;

  // BRAM read port
  logic [AWIDTH-1:0] ActBuf_Data_V_address0;
  logic              ActBuf_Data_V_ce0;

  // Status
  logic [1:0]        full_count;
  logic              err_proto;
  logic              err_range;

  modport master (
    output wr_req, wr_done, wr_addr, wr_ce, wr_we,
    output SyncSig_V_ap_ack, rd_addr, rd_ce, rd_done,
    input  wr_grant, ActBuf_Data_V_address1, ActBuf_Data_V_ce1, ActBuf_Data_V_we1,
    input  SyncSig_V, SyncSig_V_ap_vld, ActBuf_Data_V_address0, ActBuf_Data_V_ce0,
    input  full_count, err_proto, err_range
  );

  modport slave (
    input  wr_req, wr_done, wr_addr, wr_ce, wr_we,
    input  SyncSig_V_ap_ack, rd_addr, rd_ce, rd_done,
    output wr_grant, ActBuf_Data_V_address1, ActBuf_Data_V_ce1, ActBuf_Data_V_we1,
    output SyncSig_V, SyncSig_V_ap_vld, ActBuf_Data_V_address0, ActBuf_Data_V_ce0,
    output full_count, err_proto, err_range
  );

endinterface

// File: rtl/act_buf_pingpong_ctrl.sv
// ---------------------------------------------------------------------------
// act_buf_pingpong_ctrl
//   Ping-pong scheduler for the activation-buffer BRAM. The BRAM is split into
//   two banks of BANK_DEPTH words. The writer is granted an EMPTY bank, each
//   filled bank is announced to the PE over the SyncSig valid/ack handshake,
//   and a bank returns to EMPTY once the PE reports it drained. Local
//   addresses are translated to physical addresses and out-of-range or
//   out-of-phase accesses are gated off.
//
//   ap_clk : clock, rising edge
//   ap_rst : asynchronous reset, active-high
//   bus    : slave side of act_buf_pingpong_ctrl_if (writer, PE, BRAM ports,
//            full_count, sticky err_proto / err_range)
// ---------------------------------------------------------------------------
module act_buf_pingpong_ctrl #(
  parameter int DWIDTH     = 32,
  parameter int AWIDTH     = 11,
  parameter int BANK_DEPTH = 768,
  parameter int LWIDTH     = 10
) (
  input  logic                    ap_clk,
  input  logic                    ap_rst,
  act_buf_pingpong_ctrl_if.slave  bus
);

  // Elaboration-time guard on the geometry parameters.
  if (DWIDTH < 1 || 2 * BANK_DEPTH > 2 ** AWIDTH || BANK_DEPTH > 2 ** LWIDTH) begin : gParamCheck
    $error("act_buf_pingpong_ctrl: illegal DWIDTH/AWIDTH/BANK_DEPTH/LWIDTH combination");
  end

  typedef enum logic [1:0] {B_EMPTY, B_FILLING, B_FULL, B_DRAINING} bankState_e;
  typedef enum logic       {W_IDLE, W_FILL}                          wrState_e;
  typedef enum logic [1:0] {R_IDLE, R_SYNC, R_DRAIN}                 rdState_e;

  // One extra bit so a full-scale local address compares correctly.
  localparam logic [LWIDTH:0]   DEPTH_LOCAL = (LWIDTH + 1)'(BANK_DEPTH);
  localparam logic [AWIDTH-1:0] BANK1_BASE  = AWIDTH'(BANK_DEPTH);

  wrState_e   wrState, wrStateNext;
  rdState_e   rdState, rdStateNext;
  bankState_e bankState [2];
  bankState_e bankNext  [2];
  logic       wbank, rbank;
  logic       wrGrant;
  logic [1:0] fullCount, fullCountNext;
  logic       errProto, errRange;

  // -------------------------------------------------------------------------
  // Event decode, all from registered state
  // -------------------------------------------------------------------------
  logic wrStart, wrFinish, rdAnnounce, rdAccept, rdFinish;
  logic protoErr, wrOutOfRange, rdOutOfRange;

  assign wrStart    = (wrState == W_IDLE) && bus.wr_req && (bankState[wbank] == B_EMPTY);
  assign wrFinish   = (wrState == W_FILL) && bus.wr_done;
  assign rdAnnounce = (rdState == R_IDLE) && (bankState[rbank] == B_FULL);
  assign rdAccept   = (rdState == R_SYNC) && bus.SyncSig_V_ap_ack;
  assign rdFinish   = (rdState == R_DRAIN) && bus.rd_done;

  // Out-of-phase pulses are dropped; they only raise the sticky flag.
  assign protoErr = (bus.wr_done && (wrState != W_FILL))
                 || (bus.rd_done && (rdState != R_DRAIN))
                 || (bus.SyncSig_V_ap_ack && (rdState != R_SYNC));

  assign wrOutOfRange = bus.wr_ce && ({1'b0, bus.wr_addr} >= DEPTH_LOCAL);
  assign rdOutOfRange = bus.rd_ce && ({1'b0, bus.rd_addr} >= DEPTH_LOCAL);

  // -------------------------------------------------------------------------
  // State registers
  // -------------------------------------------------------------------------
  // NOTE: sequential state uses non-blocking assignments so every flop
  // samples pre-edge values, independent of process ordering.
  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      wrState <= W_IDLE;
      rdState <= R_IDLE;
    end else begin
      wrState <= wrStateNext;
      rdState <= rdStateNext;
    end
  end

  always_ff @(posedge ap_clk or posedge ap_rst) begin
    if (ap_rst) begin
      bankState[0] <= B_EMPTY;
      bankState[1] <= B_EMPTY;
      fullCount    <= 2'd0;
      wbank        <= 1'b0;
      rbank        <= 1'b0;
      wrGrant      <= 1'b0;
      errProto     <= 1'b0;
      errRange     <= 1'b0;
    end else begin
      bankState[0] <= bankNext[0];
      bankState[1] <= bankNext[1];
      fullCount    <= fullCountNext;
      wrGrant      <= wrStart;
      if (wrFinish) wbank <= ~wbank;
      if (rdFinish) rbank <= ~rbank;
      if (protoErr) errProto <= 1'b1;
      if (wrOutOfRange || rdOutOfRange) errRange <= 1'b1;
    end
  end

  // -------------------------------------------------------------------------
  // Next-state logic
  // -------------------------------------------------------------------------
  // NOTE: every always_comb output gets a default first, so no path can
  // leave a signal unassigned and infer a latch.
  always_comb begin
    wrStateNext = wrState;
    unique case (wrState)
      W_IDLE: if (wrStart)  wrStateNext = W_FILL;
      W_FILL: if (wrFinish) wrStateNext = W_IDLE;
      default:              wrStateNext = W_IDLE;
    endcase
  end

  always_comb begin
    rdStateNext = rdState;
    unique case (rdState)
      R_IDLE:  if (rdAnnounce) rdStateNext = R_SYNC;
      R_SYNC:  if (rdAccept)   rdStateNext = R_DRAIN;
      R_DRAIN: if (rdFinish)   rdStateNext = R_IDLE;
      default:                 rdStateNext = R_IDLE;
    endcase
  end

  // Writer and reader events always target banks in different states, so
  // they never collide on one entry and can both apply in the same cycle.
  always_comb begin
    bankNext[0] = bankState[0];
    bankNext[1] = bankState[1];
    if (wrStart)  bankNext[wbank] = B_FILLING;
    if (wrFinish) bankNext[wbank] = B_FULL;
    if (rdAccept) bankNext[rbank] = B_DRAINING;
    if (rdFinish) bankNext[rbank] = B_EMPTY;
    fullCountNext = 2'((bankNext[0] == B_FULL) || (bankNext[0] == B_DRAINING))
                  + 2'((bankNext[1] == B_FULL) || (bankNext[1] == B_DRAINING));
  end

  // -------------------------------------------------------------------------
  // Outputs
  // -------------------------------------------------------------------------
  // vld and SyncSig_V derive from the reader state, so an asynchronous reset
  // drops them immediately, mid-handshake included.
  always_comb begin
    bus.wr_grant               = wrGrant;
    bus.ActBuf_Data_V_ce1      = (wrState == W_FILL) && bus.wr_ce && !wrOutOfRange;
    bus.ActBuf_Data_V_we1      = (wrState == W_FILL) && bus.wr_we && !wrOutOfRange;
    bus.ActBuf_Data_V_address1 = wbank ? BANK1_BASE + AWIDTH'(bus.wr_addr)
                                       : AWIDTH'(bus.wr_addr);
    bus.SyncSig_V_ap_vld       = (rdState == R_SYNC);
    bus.SyncSig_V              = (rdState == R_SYNC) && rbank;
    bus.ActBuf_Data_V_ce0      = (rdState == R_DRAIN) && bus.rd_ce && !rdOutOfRange;
    bus.ActBuf_Data_V_address0 = rbank ? BANK1_BASE + AWIDTH'(bus.rd_addr)
                                       : AWIDTH'(bus.rd_addr);
    bus.full_count             = fullCount;
    bus.err_proto              = errProto;
    bus.err_range              = errRange;
  end

endmodule

// File: tb/tb_act_buf_pingpong_ctrl.sv
// ---------------------------------------------------------------------------
// tb_act_buf_pingpong_ctrl
//   Directed bench for act_buf_pingpong_ctrl. Scenarios run back to back and
//   each one starts from the state the previous one left behind. Inputs
//   change 1 time unit after the rising edge; outputs are checked there too.
// ---------------------------------------------------------------------------
module tb_act_buf_pingpong_ctrl;

  localparam int AWIDTH     = 11;
  localparam int LWIDTH     = 10;
  localparam int BANK_DEPTH = 768;

  logic ap_clk = 1'b0;
  logic ap_rst = 1'b1;
  int   testsRun    = 0;
  int   testsFailed = 0;

  always #5 ap_clk = ~ap_clk;

  act_buf_pingpong_ctrl_if #(.AWIDTH(AWIDTH), .LWIDTH(LWIDTH)) bus ();

  act_buf_pingpong_ctrl #(
    .DWIDTH(32), .AWIDTH(AWIDTH), .BANK_DEPTH(BANK_DEPTH), .LWIDTH(LWIDTH)
  ) dut (
    .ap_clk(ap_clk),
    .ap_rst(ap_rst),
    .bus   (bus)
  );

  task automatic step();
    @(posedge ap_clk);
    #1;
  endtask

  task automatic clear_inputs();
    bus.wr_req = 0; bus.wr_done = 0; bus.wr_addr = '0; bus.wr_ce = 0; bus.wr_we = 0;
    bus.SyncSig_V_ap_ack = 0; bus.rd_addr = '0; bus.rd_ce = 0; bus.rd_done = 0;
  endtask

  task automatic test_reset();
    clear_inputs();
    ap_rst = 1;
    step(); step();
    testsRun++;
    if ({bus.wr_grant, bus.SyncSig_V_ap_vld, bus.SyncSig_V, bus.ActBuf_Data_V_ce1,
         bus.ActBuf_Data_V_we1, bus.ActBuf_Data_V_ce0, bus.err_proto, bus.err_range} !== 8'b0) begin
      testsFailed++;
      $display("FAIL reset_flags: got %b expected 00000000", {bus.wr_grant, bus.SyncSig_V_ap_vld,
               bus.SyncSig_V, bus.ActBuf_Data_V_ce1, bus.ActBuf_Data_V_we1, bus.ActBuf_Data_V_ce0,
               bus.err_proto, bus.err_range});
    end
    testsRun++;
    if (bus.full_count !== 2'd0) begin
      testsFailed++; $display("FAIL reset_full_count: got %0d expected 0", bus.full_count);
    end
    testsRun++;
    if ({bus.ActBuf_Data_V_address1, bus.ActBuf_Data_V_address0} !== '0) begin
      testsFailed++;
      $display("FAIL reset_addr: got %0d/%0d expected 0/0", bus.ActBuf_Data_V_address1, bus.ActBuf_Data_V_address0);
    end
    ap_rst = 0;
  endtask

  // First bank: grant one cycle after request, address pass-through, announce.
  task automatic test_single_bank();
    bus.wr_req = 1;
    step();
    testsRun++;
    if (bus.wr_grant !== 1'b1) begin
      testsFailed++; $display("FAIL first_grant: got %b expected 1", bus.wr_grant);
    end
    bus.wr_req = 0; bus.wr_addr = 5; bus.wr_ce = 1; bus.wr_we = 1;
    #1;
    testsRun++;
    if ({bus.ActBuf_Data_V_address1, bus.ActBuf_Data_V_ce1, bus.ActBuf_Data_V_we1} !== {11'd5, 2'b11}) begin
      testsFailed++;
      $display("FAIL write_bank0: got addr %0d ce %b we %b expected addr 5 ce 1 we 1",
               bus.ActBuf_Data_V_address1, bus.ActBuf_Data_V_ce1, bus.ActBuf_Data_V_we1);
    end
    step();
    testsRun++;
    if (bus.wr_grant !== 1'b0) begin
      testsFailed++; $display("FAIL grant_pulse: got %b expected 0", bus.wr_grant);
    end
    bus.wr_ce = 0; bus.wr_we = 0; bus.wr_done = 1;
    step();
    bus.wr_done = 0;
    testsRun++;
    if ({bus.full_count, bus.SyncSig_V_ap_vld} !== 3'b010) begin
      testsFailed++;
      $display("FAIL after_wr_done: got count %0d vld %b expected count 1 vld 0", bus.full_count, bus.SyncSig_V_ap_vld);
    end
    bus.wr_ce = 1;
    #1;
    testsRun++;
    if (bus.ActBuf_Data_V_ce1 !== 1'b0) begin
      testsFailed++; $display("FAIL idle_ce1_gate: got %b expected 0", bus.ActBuf_Data_V_ce1);
    end
    bus.wr_ce = 0;
    step();
    testsRun++;
    if ({bus.SyncSig_V_ap_vld, bus.SyncSig_V} !== 2'b10) begin
      testsFailed++;
      $display("FAIL announce_bank0: got vld %b id %b expected vld 1 id 0", bus.SyncSig_V_ap_vld, bus.SyncSig_V);
    end
  endtask

  // Second bank, blocked third request, held-off ack, drain and recycle.
  task automatic test_both_banks();
    bus.wr_req = 1;
    step();
    testsRun++;
    if (bus.wr_grant !== 1'b1) begin
      testsFailed++; $display("FAIL second_grant: got %b expected 1", bus.wr_grant);
    end
    bus.wr_req = 0; bus.wr_addr = 10; bus.wr_ce = 1;
    #1;
    testsRun++;
    if (bus.ActBuf_Data_V_address1 !== 11'd778) begin
      testsFailed++; $display("FAIL write_bank1_addr: got %0d expected 778", bus.ActBuf_Data_V_address1);
    end
    bus.wr_ce = 0; bus.wr_done = 1;
    step();
    bus.wr_done = 0;
    testsRun++;
    if (bus.full_count !== 2'd2) begin
      testsFailed++; $display("FAIL full_count_two: got %0d expected 2", bus.full_count);
    end
    bus.wr_req = 1;
    step(); step(); step();
    testsRun++;
    if ({bus.wr_grant, bus.full_count} !== 3'b010) begin
      testsFailed++;
      $display("FAIL blocked_request: got grant %b count %0d expected grant 0 count 2", bus.wr_grant, bus.full_count);
    end
    for (int i = 0; i < 10; i++) begin
      step();
      testsRun++;
      if ({bus.SyncSig_V_ap_vld, bus.SyncSig_V, bus.wr_grant} !== 3'b100) begin
        testsFailed++;
        $display("FAIL hold_vld cycle %0d: got vld %b id %b grant %b expected 1 0 0",
                 i, bus.SyncSig_V_ap_vld, bus.SyncSig_V, bus.wr_grant);
      end
    end
    bus.SyncSig_V_ap_ack = 1;
    step();
    bus.SyncSig_V_ap_ack = 0;
    testsRun++;
    if ({bus.SyncSig_V_ap_vld, bus.full_count} !== 3'b010) begin
      testsFailed++;
      $display("FAIL after_ack: got vld %b count %0d expected vld 0 count 2", bus.SyncSig_V_ap_vld, bus.full_count);
    end
    bus.rd_addr = 767; bus.rd_ce = 1;
    #1;
    testsRun++;
    if ({bus.ActBuf_Data_V_address0, bus.ActBuf_Data_V_ce0} !== {11'd767, 1'b1}) begin
      testsFailed++;
      $display("FAIL read_bank0: got addr %0d ce %b expected addr 767 ce 1", bus.ActBuf_Data_V_address0, bus.ActBuf_Data_V_ce0);
    end
    bus.rd_ce = 0; bus.rd_done = 1;
    step();
    bus.rd_done = 0;
    testsRun++;
    if ({bus.wr_grant, bus.full_count} !== 3'b001) begin
      testsFailed++;
      $display("FAIL no_bypass_grant: got grant %b count %0d expected grant 0 count 1", bus.wr_grant, bus.full_count);
    end
    step();
    testsRun++;
    if (bus.wr_grant !== 1'b1) begin
      testsFailed++; $display("FAIL recycle_grant: got %b expected 1", bus.wr_grant);
    end
    bus.wr_req = 0; bus.wr_addr = 5;
    #1;
    testsRun++;
    if ({bus.ActBuf_Data_V_address1, bus.SyncSig_V_ap_vld, bus.SyncSig_V} !== {11'd5, 2'b11}) begin
      testsFailed++;
      $display("FAIL recycle_state: got addr %0d vld %b id %b expected addr 5 vld 1 id 1",
               bus.ActBuf_Data_V_address1, bus.SyncSig_V_ap_vld, bus.SyncSig_V);
    end
    bus.SyncSig_V_ap_ack = 1;
    step();
    bus.SyncSig_V_ap_ack = 0; bus.rd_addr = 767; bus.rd_ce = 1;
    #1;
    testsRun++;
    if (bus.ActBuf_Data_V_address0 !== 11'd1535) begin
      testsFailed++; $display("FAIL read_bank1_addr: got %0d expected 1535", bus.ActBuf_Data_V_address0);
    end
    bus.rd_ce = 0;
  endtask

  // wr_done on bank 0 and rd_done on bank 1 in the same cycle.
  task automatic test_back_to_back();
    bus.wr_done = 1; bus.rd_done = 1;
    step();
    bus.wr_done = 0; bus.rd_done = 0;
    testsRun++;
    if ({bus.full_count, bus.err_proto} !== 3'b010) begin
      testsFailed++;
      $display("FAIL dual_done: got count %0d err_proto %b expected count 1 err_proto 0", bus.full_count, bus.err_proto);
    end
    step();
    testsRun++;
    if ({bus.SyncSig_V_ap_vld, bus.SyncSig_V} !== 2'b10) begin
      testsFailed++;
      $display("FAIL dual_done_announce: got vld %b id %b expected vld 1 id 0", bus.SyncSig_V_ap_vld, bus.SyncSig_V);
    end
  endtask

  task automatic test_range();
    bus.wr_req = 1;
    step();
    testsRun++;
    if (bus.wr_grant !== 1'b1) begin
      testsFailed++; $display("FAIL range_grant: got %b expected 1", bus.wr_grant);
    end
    bus.wr_req = 0; bus.wr_addr = 768; bus.wr_ce = 1; bus.wr_we = 1;
    #1;
    testsRun++;
    if ({bus.ActBuf_Data_V_ce1, bus.ActBuf_Data_V_we1} !== 2'b00) begin
      testsFailed++;
      $display("FAIL range_gate: got ce %b we %b expected 0 0", bus.ActBuf_Data_V_ce1, bus.ActBuf_Data_V_we1);
    end
    step();
    bus.wr_addr = 3;
    #1;
    testsRun++;
    if ({bus.err_range, bus.ActBuf_Data_V_ce1, bus.ActBuf_Data_V_address1} !== {2'b11, 11'd771}) begin
      testsFailed++;
      $display("FAIL range_sticky: got err %b ce %b addr %0d expected err 1 ce 1 addr 771",
               bus.err_range, bus.ActBuf_Data_V_ce1, bus.ActBuf_Data_V_address1);
    end
    bus.wr_ce = 0; bus.wr_we = 0; bus.wr_done = 1;
    step();
    bus.wr_done = 0;
    testsRun++;
    if ({bus.full_count, bus.err_range} !== 3'b101) begin
      testsFailed++;
      $display("FAIL range_fill_done: got count %0d err %b expected count 2 err 1", bus.full_count, bus.err_range);
    end
  endtask

  task automatic test_proto();
    bus.SyncSig_V_ap_ack = 1;
    step();
    bus.SyncSig_V_ap_ack = 0; bus.rd_done = 1;
    step();
    bus.rd_done = 0;
    testsRun++;
    if ({bus.full_count, bus.err_proto} !== 3'b010) begin
      testsFailed++;
      $display("FAIL drain_bank0: got count %0d err_proto %b expected count 1 err_proto 0", bus.full_count, bus.err_proto);
    end
    bus.rd_done = 1;
    step();
    bus.rd_done = 0;
    testsRun++;
    if ({bus.err_proto, bus.full_count, bus.SyncSig_V_ap_vld, bus.SyncSig_V} !== 5'b10111) begin
      testsFailed++;
      $display("FAIL idle_rd_done: got err %b count %0d vld %b id %b expected err 1 count 1 vld 1 id 1",
               bus.err_proto, bus.full_count, bus.SyncSig_V_ap_vld, bus.SyncSig_V);
    end
  endtask

  task automatic test_async_reset();
    testsRun++;
    if (bus.SyncSig_V_ap_vld !== 1'b1) begin
      testsFailed++; $display("FAIL pre_reset_vld: got %b expected 1", bus.SyncSig_V_ap_vld);
    end
    #3;
    ap_rst = 1;
    #1;
    testsRun++;
    if ({bus.SyncSig_V_ap_vld, bus.full_count, bus.err_proto, bus.err_range} !== 5'b0) begin
      testsFailed++;
      $display("FAIL async_reset: got vld %b count %0d errs %b%b expected all 0",
               bus.SyncSig_V_ap_vld, bus.full_count, bus.err_proto, bus.err_range);
    end
    step(); step();
    ap_rst = 0;
    bus.wr_req = 1; bus.wr_addr = 5;
    step();
    bus.wr_req = 0;
    testsRun++;
    if ({bus.wr_grant, bus.ActBuf_Data_V_address1} !== {1'b1, 11'd5}) begin
      testsFailed++;
      $display("FAIL post_reset_grant: got grant %b addr %0d expected grant 1 addr 5", bus.wr_grant, bus.ActBuf_Data_V_address1);
    end
  endtask

  initial begin
    test_reset();
    test_single_bank();
    test_both_banks();
    test_back_to_back();
    test_range();
    test_proto();
    test_async_reset();
    $display("[TB] %0d tests run, %0d failed", testsRun, testsFailed);
    $finish;
  end

endmodule
